// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, per-pixel control bundle and RGB444 colour expansion.
// Declarations only: no latency, no flow control.
package vga_pkg;

  localparam int PIX_W = 12;
  localparam int CW    = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic frame_start;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [23:0] rgb444_to_888(input logic [PIX_W-1:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

endpackage

// File: rtl/vga_fb_ctrl_if.sv
// Producer-side bus of the framebuffer: pixel write port plus swap handshake.
// Writes are accepted whenever wr_ready is high; swap requests are coalesced while pending.
interface vga_fb_ctrl_if;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [9:0]                wr_x;
  logic [8:0]                wr_y;
  logic [vga_pkg::PIX_W-1:0] wr_data;
  logic                      swap_req;
  logic                      swap_pending;
  logic                      swap_done;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data, swap_req,
    input  wr_ready, swap_pending, swap_done
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, swap_req,
    output wr_ready, swap_pending, swap_done
  );

endinterface

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/blank/frame strobes describing the current count.
// Free-running from reset; takes no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output vid_ctl_t      ctl,
  output logic          swap_slot
);

  localparam logic [CW-1:0] H_LAST = CW'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CW-1:0] V_LAST = CW'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    ctl.blank_n     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    ctl.hsync       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    ctl.vsync       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    ctl.frame_start = (h_cnt == '0) && (v_cnt == '0);
    // First clock of the first blank line: the only place a bank swap may happen.
    swap_slot       = (h_cnt == '0) && (v_cnt == V_VIS);
  end

endmodule

// File: rtl/vga_fb_ctrl.sv
// Double-buffered framebuffer with VGA scan-out; sync, blank and colour all leave 2 clocks after the counters.
// Write port never stalls outside reset; swaps wait for the first blank line of a frame.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SCALE_SH = 1
) (
  input  logic         clk,
  input  logic         rst,
  vga_fb_ctrl_if.slave bus,
  output logic         front_sel,
  output logic         frame_start,
  output logic         wr_oob,
  output logic         hsync,
  output logic         vsync,
  output logic         blank_n,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b
);

  localparam int FB_W  = H_ACTIVE >> SCALE_SH;
  localparam int FB_H  = V_ACTIVE >> SCALE_SH;
  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(2 * DEPTH);

  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  vid_ctl_t         ctl0;
  vid_ctl_t         ctl1;
  vid_ctl_t         ctl2;
  logic             swap_slot;
  logic             swap_pend;
  logic             wr_in_range;
  logic             wr_fire;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_dat;
  logic [23:0]      rgb2;
  logic [PIX_W-1:0] mem [2*DEPTH];

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .ctl       (ctl0),
    .swap_slot (swap_slot)
  );

  assign bus.wr_ready     = !rst;
  assign bus.swap_pending = swap_pend;
  assign bus.swap_done    = swap_slot && swap_pend;

  assign wr_in_range = (32'(bus.wr_x) < 32'(FB_W)) && (32'(bus.wr_y) < 32'(FB_H));
  assign wr_fire     = bus.wr_valid && bus.wr_ready && wr_in_range;

  // Writes land in the bank not being shown, using front_sel as it stands this
  // cycle, so a write coinciding with the swap still targets the old back bank.
  assign wr_addr = AW'(bus.wr_y) * AW'(FB_W) + AW'(bus.wr_x)
                 + (front_sel ? AW'(0) : AW'(DEPTH));

  always_comb begin
    rd_addr = '0;
    if (ctl0.blank_n) begin
      rd_addr = AW'(v_cnt >> SCALE_SH) * AW'(FB_W) + AW'(h_cnt >> SCALE_SH)
              + (front_sel ? AW'(DEPTH) : AW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= bus.wr_data;
    end
    rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel <= 1'b0;
      swap_pend <= 1'b0;
      wr_oob    <= 1'b0;
      ctl1      <= CTL_IDLE;
      ctl2      <= CTL_IDLE;
      rgb2      <= '0;
    end else begin
      if (bus.swap_done) begin
        front_sel <= !front_sel;
        swap_pend <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pend <= 1'b1;
      end
      if (bus.wr_valid && !wr_in_range) begin
        wr_oob <= 1'b1;
      end
      ctl1 <= ctl0;
      ctl2 <= ctl1;
      rgb2 <= ctl1.blank_n ? rgb444_to_888(rd_dat) : '0;
    end
  end

  assign hsync       = ctl2.hsync;
  assign vsync       = ctl2.vsync;
  assign blank_n     = ctl2.blank_n;
  assign frame_start = ctl2.frame_start;
  assign vga_r       = rgb2[23:16];
  assign vga_g       = rgb2[15:8];
  assign vga_b       = rgb2[7:0];

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl on an 8x4 raster; a monitor checks timing every clock
// and pops expected visible pixels from a scoreboard queue filled by the stimulus.
module tb_vga_fb_ctrl;

  localparam int HT = 12;
  localparam int VT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       front_sel, frame_start, wr_oob, hsync, vsync, blank_n;
  logic [7:0] vga_r, vga_g, vga_b;

  int checks = 0;
  int fails  = 0;

  int          ah = 0;
  int          av = 0;
  bit          synced = 1'b0;
  bit          armed  = 1'b0;
  bit          mon_vis;
  logic [23:0] mon_exp;
  logic [23:0] exp_q [$];
  int          done_cnt = 0;
  int          done_base;

  vga_fb_ctrl_if bus ();

  vga_fb_ctrl #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SCALE_SH (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .front_sel   (front_sel),
    .frame_start (frame_start),
    .wr_oob      (wr_oob),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp888(input logic [11:0] p);
    logic [7:0] r, g, b;
    r = 8'(p[11:8]) * 8'h11;
    g = 8'(p[7:4]) * 8'h11;
    b = 8'(p[3:0]) * 8'h11;
    return {r, g, b};
  endfunction

  function automatic logic [11:0] pat1(input int x, input int y);
    return 12'(x * 256 + y * 16 + 12);
  endfunction

  function automatic logic [11:0] pat0(input int x, input int y);
    return 12'(y * 256 + x * 16 + 3);
  endfunction

  // Monitor: independent raster model locked to the first frame_start after reset.
  always @(negedge clk) begin
    if (bus.swap_done) done_cnt++;
    if (rst) begin
      synced = 1'b0;
      armed  = 1'b0;
    end else begin
      if (synced) begin
        ah++;
        if (ah == HT) begin
          ah = 0;
          av++;
          if (av == VT) av = 0;
        end
      end else if (frame_start) begin
        synced = 1'b1;
        ah = 0;
        av = 0;
      end
      if (synced) begin
        mon_vis = (ah < 8) && (av < 4);
        chk("frame_start", frame_start, (ah == 0 && av == 0));
        chk("hsync", hsync, !(ah >= 9 && ah < 11));
        chk("vsync", vsync, (av != 5));
        chk("blank_n", blank_n, mon_vis);
        if (ah == 0 && av == 0) armed = (exp_q.size() >= 32);
        if (av == 4) armed = 1'b0;
        if (!mon_vis) begin
          chk("rgb_in_blank", {vga_r, vga_g, vga_b}, 0);
        end else if (armed) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            chk($sformatf("pixel(%0d,%0d)", ah, av), {vga_r, vga_g, vga_b}, mon_exp);
          end
        end
      end
    end
  end

  task automatic wr(input int x, input int y, input logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_x     = 10'(x);
    bus.wr_y     = 9'(y);
    bus.wr_data  = d;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    @(posedge clk); #1;
    bus.swap_req = 1'b0;
  endtask

  task automatic wait_aligned(input int x, input int y, input int budget);
    bit hit = 1'b0;
    int n = 0;
    while (!hit && n < budget) begin
      @(negedge clk); #1;
      n++;
      hit = synced && (ah == x) && (av == y);
    end
    chk($sformatf("reach_aligned(%0d,%0d)", x, y), hit, 1);
  endtask

  task automatic wait_swap_done(input int budget);
    bit hit = 1'b0;
    int n = 0;
    while (!hit && n < budget) begin
      @(negedge clk); #1;
      n++;
      hit = bus.swap_done;
    end
    chk("swap_done_seen", hit, 1);
  endtask

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_consumed", exp_q.size(), 0);
  endtask

  task automatic release_and_check_fs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("fs_after_1clk", frame_start, 0);
    @(posedge clk); #1;
    chk("fs_after_2clk", frame_start, 1);
    @(negedge clk); #1;
  endtask

  task automatic push_bank1_frame(input bit with_123);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (x == 3 && y == 2)               exp_q.push_back(24'hFF00AA);
        else if (with_123 && x == 0 && y == 0) exp_q.push_back(24'h112233);
        else                                exp_q.push_back(exp888(pat1(x, y)));
      end
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_x     = '0;
    bus.wr_y     = '0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_blank_n", blank_n, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_front_sel", front_sel, 0);
    chk("rst_swap_pending", bus.swap_pending, 0);
    chk("rst_swap_done", bus.swap_done, 0);
    chk("rst_wr_oob", wr_oob, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);

    release_and_check_fs();
    chk("wr_ready_run", bus.wr_ready, 1);
    wait_aligned(0, 0, 200);
    wait_aligned(0, 0, 200);

    // Preload bank 1, mark (3,2), then swap
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        wr(x, y, pat1(x, y));
    wr(3, 2, 12'hF0A);
    pulse_swap();
    chk("pending_after_req", bus.swap_pending, 1);
    wait_swap_done(200);
    chk("swap_position", av * HT + ah, 3 * HT + 10);
    @(posedge clk); #1;
    chk("front_after_swap1", front_sel, 1);
    chk("pending_after_swap1", bus.swap_pending, 0);
    chk("done_is_pulse", bus.swap_done, 0);
    push_bank1_frame(1'b0);
    wait_q_empty(300);

    // Coalesce: preload bank 0, three requests inside one frame
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        wr(x, y, pat0(x, y));
    wait_aligned(0, 0, 200);
    done_base = done_cnt;
    pulse_swap();
    repeat (3) @(posedge clk); #1;
    pulse_swap();
    repeat (3) @(posedge clk); #1;
    pulse_swap();
    chk("pending_coalesced", bus.swap_pending, 1);
    wait_swap_done(200);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        exp_q.push_back(exp888(pat0(x, y)));
    wait_q_empty(300);
    repeat (100) @(posedge clk); #1;
    chk("coalesce_done_count", done_cnt - done_base, 1);
    chk("coalesce_front", front_sel, 0);

    // Out-of-range write to bank 1 (x=8 would alias (0,1) without the range check)
    wr(8, 0, 12'hFFF);
    chk("oob_set", wr_oob, 1);

    // Write (0,0) in the swap cycle itself
    pulse_swap();
    wait_aligned(9, 3, 200);
    @(posedge clk); #1;
    bus.wr_valid = 1'b1;
    bus.wr_x     = 10'd0;
    bus.wr_y     = 9'd0;
    bus.wr_data  = 12'h123;
    @(negedge clk); #1;
    chk("swap_with_write", bus.swap_done, 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    chk("front_after_swap3", front_sel, 1);
    push_bank1_frame(1'b1);
    wait_q_empty(300);
    wait_aligned(0, 0, 200);
    chk("oob_sticky", wr_oob, 1);

    // Reset mid-frame at stage-0 (5,2) with a swap pending
    wait_aligned(0, 1, 200);
    pulse_swap();
    wait_aligned(3, 2, 200);
    chk("pre_rst_blank_n", blank_n, 1);
    chk("pre_rst_pending", bus.swap_pending, 1);
    chk("pre_rst_front", front_sel, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_pending", bus.swap_pending, 0);
    chk("midrst_front", front_sel, 0);
    chk("midrst_hsync", hsync, 1);
    chk("midrst_vsync", vsync, 1);
    chk("midrst_blank_n", blank_n, 0);
    chk("midrst_oob", wr_oob, 0);
    repeat (2) @(posedge clk);
    release_and_check_fs();
    wait_aligned(0, 0, 200);
    chk("post_rst_front", front_sel, 0);
    chk("post_rst_oob", wr_oob, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_ctrl.md
Name: vga_fb_ctrl

Overview:
- Parametrised VGA timing generator with a double-buffered, writeable framebuffer. It replaces the static preloaded picture memory plus fixed-timing controller pair.
- A producer (CPU/test logic) writes pixels into the back buffer through a valid/ready port. The front buffer is scanned out with sync signals aligned to the pixel data.
- A swap request exchanges the buffers at the next vertical-blank boundary. This gives tear-free updates.
- Sits directly under top; drives VGA_HSYNC/VGA_VSYNC/VGA_BLANK_N/VGA_R/G/B. VGA_CLK = clk as today.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SCALE_SH, 1, log2 pixel replication; buffer is (H_ACTIVE>>SCALE_SH) x (V_ACTIVE>>SCALE_SH)
- PIX_W, 12, stored pixel width; RGB444 only (PIX_W=12 fixed in this revision)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when wr_valid&wr_ready
- wr_x  in  10  buffer column (scaled coordinates)
- wr_y  in  9  buffer row (scaled coordinates)
- wr_data  in  PIX_W  {R[3:0],G[3:0],B[3:0]}
- swap_req  in  1  one-cycle pulse: request buffer swap
- swap_pending  out  1  swap requested, not yet performed
- swap_done  out  1  one-cycle pulse on swap
- front_sel  out  1  index of bank being displayed
- frame_start  out  1  pulse when aligned output is at pixel (0,0)
- wr_oob  out  1  sticky: an out-of-range write was dropped
- hsync  out  1  active-low
- vsync  out  1  active-low
- blank_n  out  1  high during visible region
- vga_r, vga_g, vga_b  out  8 each  pixel colour

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps, running 0..V_TOTAL-1, then wraps to 0.
  - Visible region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - Sync is asserted (0) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); same rule for vsync on v_cnt.
- Pipeline, fixed latency 2:
  - Stage 0: counters.
  - Stage 1: read address = (v_cnt>>SCALE_SH)*FB_W + (h_cnt>>SCALE_SH) in the front bank; synchronous read.
  - Stage 2: registered outputs.
  - hsync/vsync/blank_n/frame_start are delayed 2 cycles so all outputs describe the same pixel.
- Colour: each 4-bit channel is expanded to 8 bits by nibble replication (e.g. 4'hA -> 8'hAA). RGB is forced to 0 when blank_n=0.
- Write port:
  - wr_ready=1 whenever rst=0.
  - An accepted write stores wr_data at wr_y*FB_W+wr_x in bank ~front_sel.
  - wr_x>=FB_W or wr_y>=FB_H: no store; wr_oob sets and holds until rst.
- Swap:
  - swap_req sets swap_pending. Further requests while pending are coalesced.
  - At the stage-0 cycle with h_cnt==0 and v_cnt==V_ACTIVE (first blank line), if pending: front_sel toggles, swap_pending clears, swap_done pulses for that cycle.
  - swap_req in that same cycle with pending=0 is not taken; it is serviced next frame.
  - A write in the swap cycle goes to the pre-swap back bank.
  - Buffers are not copied on swap; the new back bank holds the frame from two swaps ago.
- Reset:
  - Counters 0; pipeline cleared; front_sel=0; swap_pending=0; swap_done=0; wr_oob=0.
  - Outputs: hsync=1, vsync=1, blank_n=0, rgb=0, frame_start=0.
  - Memory contents are not cleared.
  - Reset mid-frame restarts timing at (0,0); the first aligned frame_start occurs 2 cycles after rst deasserts.
- Memory: two banks of FB_W*FB_H words. Inferred dual-port storage: one write port, one read port.

Decomposition:
- Shared package vga_pkg: timing defaults (640x480@60 constants), the rgb444_to_888 expansion function, and the H_TOTAL/V_TOTAL derivation helpers.
- One natural sub-module, vga_timing: counters, sync, blank and frame-boundary strobes. The vga_fb_ctrl top level holds the banks, write port, swap logic and alignment pipeline.

Test Plan:
- Use small params (H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SCALE_SH=0).
- Timing:
  - Stimulus: release reset, run two frames.
  - Required: line period 12 clocks; hsync low for 2 clocks starting at aligned h=9; vsync low for 1 line starting at line 5; blank_n high for 8x4 pixels; frame_start every 84 clocks.
- Write then swap:
  - Stimulus: write (3,2)=12'hF0A, then pulse swap_req.
  - Required: swap_done at the next h=0, v=4 cycle; front_sel=1; the next frame shows RGB=FF,00,AA at aligned pixel (3,2); all other pixels match the bank-1 preload.
- Coalesce:
  - Stimulus: three swap_req pulses within one frame.
  - Required: exactly one swap_done; front_sel toggles once.
- Out of range:
  - Stimulus: write x=8.
  - Required: no memory change; wr_oob=1 and stays 1 across frames until rst.
- Simultaneous swap and write:
  - Stimulus: write (0,0)=12'h123 in the swap cycle with pending=1.
  - Required: the data lands in the old back bank and is visible after the swap (R=11, G=22, B=33).
- Reset mid-frame:
  - Stimulus: assert rst at h=5, v=2 with pending=1.
  - Required: swap_pending=0, front_sel=0, hsync=vsync=1, blank_n=0; timing restarts from (0,0).
